// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state encodings shared by the accumulator slice
package alu_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/add_subt_16bits.sv
// rtl/add_subt_16bits.sv - 16-bit add/subtract; x=1 selects op0 - op1, cout=1 means no borrow
module add_subt_16bits (
    input  logic [15:0] op0,
    input  logic [15:0] op1,
    input  logic        x,
    output logic [15:0] result,
    output logic        cout
);

    logic [15:0] w_op1_x;
    logic        w_c_mid;

    // Two's complement subtract: invert op1 and inject x as the low carry in.
    xor_gate #(.W(16)) U_XOR (
        .i_a (op1),
        .i_b ({16{x}}),
        .o_y (w_op1_x)
    );

    fa_8bits U_FA_LO (
        .i_a    (op0[7:0]),
        .i_b    (w_op1_x[7:0]),
        .i_cin  (x),
        .o_sum  (result[7:0]),
        .o_cout (w_c_mid)
    );

    fa_8bits U_FA_HI (
        .i_a    (op0[15:8]),
        .i_b    (w_op1_x[15:8]),
        .i_cin  (w_c_mid),
        .o_sum  (result[15:8]),
        .o_cout (cout)
    );

endmodule

// File: rtl/fa_8bits.sv
// rtl/fa_8bits.sv - 8-bit adder with carry in and carry out
module fa_8bits (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};

endmodule

// File: rtl/xor_gate.sv
// rtl/xor_gate.sv - bitwise xor of two vectors
module xor_gate #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    assign o_y = i_a ^ i_b;

endmodule

// File: rtl/acc_ctrl_16bits.sv
// rtl/acc_ctrl_16bits.sv - two-state command sequencer and flag storage around add_subt_16bits
module acc_ctrl_16bits
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  opcode,
    input  logic [15:0] operand,
    output logic [15:0] acc,
    output logic        carry,
    output logic        overflow,
    output logic        ovf_sticky,
    output logic        zero,
    output logic        out_valid
);

    state_t      r_state;
    state_t      w_next;
    op_t         r_op;
    logic [15:0] r_opd;
    logic [15:0] r_acc;
    logic        r_carry;
    logic        r_overflow;
    logic        r_ovf_sticky;
    logic        r_zero;
    logic        r_out_valid;

    logic [15:0] w_result;
    logic        w_cout;
    logic        w_ovf_new;
    logic        w_accept;

    add_subt_16bits U_ADDSUB (
        .op0    (r_acc),
        .op1    (r_opd),
        .x      (r_op == OP_SUB),
        .result (w_result),
        .cout   (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
    end

    assign w_accept = in_ready && in_valid;

    always_comb begin
        w_ovf_new = 1'b0;
        if (r_op == OP_ADD)
            w_ovf_new = (r_acc[15] == r_opd[15]) && (w_result[15] != r_acc[15]);
        else if (r_op == OP_SUB)
            w_ovf_new = (r_acc[15] != r_opd[15]) && (w_result[15] != r_acc[15]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= OP_LOAD;
            r_opd        <= '0;
            r_acc        <= '0;
            r_carry      <= 1'b0;
            r_overflow   <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_zero       <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= (r_state == ST_EXEC);
            if (w_accept) begin
                r_op  <= op_t'(opcode);
                r_opd <= operand;
            end
            if (r_state == ST_EXEC) begin
                case (r_op)
                    OP_ADD, OP_SUB: begin
                        r_acc        <= w_result;
                        r_carry      <= w_cout;
                        r_overflow   <= w_ovf_new;
                        r_ovf_sticky <= r_ovf_sticky | w_ovf_new;
                        r_zero       <= (w_result == 16'd0);
                    end
                    OP_LOAD: begin
                        r_acc        <= r_opd;
                        r_carry      <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_ovf_sticky <= 1'b0;
                        r_zero       <= (r_opd == 16'd0);
                    end
                    default: begin
                        r_acc        <= '0;
                        r_carry      <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_ovf_sticky <= 1'b0;
                        r_zero       <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign acc        = r_acc;
    assign carry      = r_carry;
    assign overflow   = r_overflow;
    assign ovf_sticky = r_ovf_sticky;
    assign zero       = r_zero;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_acc_ctrl_16bits.sv
// tb/tb_acc_ctrl_16bits.sv - vector table, corner sequences and random commands against an arithmetic model
module tb_acc_ctrl_16bits;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  opcode;
    logic [15:0] operand;
    logic [15:0] acc;
    logic        carry;
    logic        overflow;
    logic        ovf_sticky;
    logic        zero;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_acc;
    logic        m_carry;
    logic        m_ovf;
    logic        m_sticky;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] opd;
        logic [15:0] e_acc;
        logic        e_c;
        logic        e_v;
        logic        e_s;
        logic        e_z;
    } vec_t;

    vec_t vecs[13];

    acc_ctrl_16bits dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .operand    (operand),
        .acc        (acc),
        .carry      (carry),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky),
        .zero       (zero),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 16'd0; m_carry = 1'b0; m_ovf = 1'b0; m_sticky = 1'b0;
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model_step(input logic [1:0] op, input logic [15:0] opd);
        int unsigned ua, ub;
        int          sa, sb, sr;
        ua = int'(m_acc);
        ub = int'(opd);
        sa = int'($signed(m_acc));
        sb = int'($signed(opd));
        case (op)
            2'b00: begin m_acc = opd;   m_carry = 0; m_ovf = 0; m_sticky = 0; end
            2'b11: begin m_acc = 16'd0; m_carry = 0; m_ovf = 0; m_sticky = 0; end
            2'b01: begin
                m_carry  = (ua + ub) > 65535;
                sr       = sa + sb;
                m_ovf    = (sr > 32767) || (sr < -32768);
                m_acc    = 16'(ua + ub);
                m_sticky = m_sticky | m_ovf;
            end
            default: begin
                m_carry  = (ua >= ub);
                sr       = sa - sb;
                m_ovf    = (sr > 32767) || (sr < -32768);
                m_acc    = 16'(ua - ub);
                m_sticky = m_sticky | m_ovf;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, "_acc"},    {16'd0, acc},      {16'd0, m_acc});
        check({tag, "_carry"},  {31'd0, carry},    {31'd0, m_carry});
        check({tag, "_ovf"},    {31'd0, overflow}, {31'd0, m_ovf});
        check({tag, "_sticky"}, {31'd0, ovf_sticky}, {31'd0, m_sticky});
        check({tag, "_zero"},   {31'd0, zero},     {31'd0, (m_acc == 16'd0)});
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic issue(input logic [1:0] op, input logic [15:0] opd, input string tag);
        int n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (!in_ready) begin
            check({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1; opcode = op; operand = opd;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        opcode   = 2'($urandom);
        operand  = 16'($urandom);
        check({tag, "_exec_ready"}, {31'd0, in_ready}, 0);
        check({tag, "_exec_ov"},    {31'd0, out_valid}, 0);
        @(posedge clk); @(negedge clk);
        model_step(op, opd);
        check({tag, "_ov_pulse"}, {31'd0, out_valid}, 1);
        check({tag, "_ready"},    {31'd0, in_ready}, 1);
        check_model(tag);
        @(posedge clk); @(negedge clk);
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 0);
    endtask

    initial begin
        int          accepts, pulses;
        logic [9:0]  amask, pmask;
        logic [1:0]  rop;
        logic [15:0] ropd;

        vecs[0]  = '{2'b00, 16'h1234, 16'h1234, 0, 0, 0, 0};
        vecs[1]  = '{2'b00, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0};
        vecs[2]  = '{2'b01, 16'h0001, 16'h8000, 0, 1, 1, 0};
        vecs[3]  = '{2'b01, 16'h0000, 16'h8000, 0, 0, 1, 0};
        vecs[4]  = '{2'b10, 16'h0001, 16'h7FFF, 1, 1, 1, 0};
        vecs[5]  = '{2'b00, 16'h0005, 16'h0005, 0, 0, 0, 0};
        vecs[6]  = '{2'b10, 16'h0005, 16'h0000, 1, 0, 0, 1};
        vecs[7]  = '{2'b10, 16'h0001, 16'hFFFF, 0, 0, 0, 0};
        vecs[8]  = '{2'b00, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0};
        vecs[9]  = '{2'b01, 16'h0001, 16'h0000, 1, 0, 0, 1};
        vecs[10] = '{2'b00, 16'h8000, 16'h8000, 0, 0, 0, 0};
        vecs[11] = '{2'b01, 16'h8000, 16'h0000, 1, 1, 1, 1};
        vecs[12] = '{2'b11, 16'h1234, 16'h0000, 0, 0, 0, 1};

        rst = 1'b1; in_valid = 1'b0; opcode = 2'b00; operand = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_acc",   {16'd0, acc}, 0);
        check("rst_zero",  {31'd0, zero}, 1);
        check("rst_flags", {29'd0, carry, overflow, ovf_sticky}, 0);
        check("rst_ov",    {31'd0, out_valid}, 0);
        check("rst_ready", {31'd0, in_ready}, 1);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].opd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_acc", i), {16'd0, acc}, {16'd0, vecs[i].e_acc});
            check($sformatf("vec%0d_tbl_flags", i), {28'd0, carry, overflow, ovf_sticky, zero},
                  {28'd0, vecs[i].e_c, vecs[i].e_v, vecs[i].e_s, vecs[i].e_z});
        end

        // in_valid held high: four ADDs must be accepted on alternate edges.
        accepts = 0; pulses = 0; amask = '0; pmask = '0;
        in_valid = 1'b1; opcode = 2'b01; operand = 16'h0010;
        for (int c = 0; c < 10; c++) begin
            if (in_ready && in_valid) begin
                accepts++; amask[c] = 1'b1; model_step(2'b01, 16'h0010);
            end
            @(posedge clk); @(negedge clk);
            if (out_valid) begin pulses++; pmask[c] = 1'b1; end
            if (accepts == 4) in_valid = 1'b0;
        end
        check("b2b_accept_mask", {22'd0, amask}, 32'h055);
        check("b2b_pulse_mask",  {22'd0, pmask}, 32'h0AA);
        check("b2b_pulses",      pulses, 4);
        check("b2b_acc",         {16'd0, acc}, 32'h0040);
        check_model("b2b");

        // Reset landing on EXEC discards the command.
        issue(2'b00, 16'h00AA, "pre_abort");
        in_valid = 1'b1; opcode = 2'b01; operand = 16'h0001;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; model_reset();
        check("abort_ov",    {31'd0, out_valid}, 0);
        check("abort_acc",   {16'd0, acc}, 0);
        check("abort_zero",  {31'd0, zero}, 1);
        check("abort_ready", {31'd0, in_ready}, 1);
        @(posedge clk); @(negedge clk);
        check("abort_ov_late", {31'd0, out_valid}, 0);

        // Reset together with in_valid in IDLE: nothing accepted.
        issue(2'b00, 16'h0042, "pre_rstidle");
        rst = 1'b1; in_valid = 1'b1; opcode = 2'b00; operand = 16'h5555;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; model_reset();
        check("rstidle_ready", {31'd0, in_ready}, 1);
        @(posedge clk); @(negedge clk);
        check("rstidle_ov",  {31'd0, out_valid}, 0);
        check("rstidle_acc", {16'd0, acc}, 0);

        for (int k = 0; k < 200; k++) begin
            rop  = 2'($urandom_range(0, 9) < 2 ? ($urandom_range(0, 1) ? 0 : 3) : $urandom_range(1, 2));
            ropd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3) * 16'h4000 - $urandom_range(0, 1))
                                              : 16'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
            issue(rop, ropd, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
